// File: rtl/ttc_apb_if_lite22_if.sv
// ----------------------------------------------------------------------------
// ttc_apb_if_lite22_if
// APB3 bus bundle between the APB bridge and the TTC register front end.
//   psel22, penable22, pwrite22 : transfer control (master -> slave)
//   paddr22 [ADDR_W]            : byte address       (master -> slave)
//   pwdata22 [16]               : write data         (master -> slave)
//   prdata22 [16]               : read data          (slave -> master)
//   pready22, pslverr22         : completion/error   (slave -> master)
// ----------------------------------------------------------------------------
interface ttc_apb_if_lite22_if #(
    parameter int ADDR_W = 8
);
    logic              psel22;
    logic              penable22;
    logic              pwrite22;
    logic [ADDR_W-1:0] paddr22;
    logic [15:0]       pwdata22;
    logic [15:0]       prdata22;
    logic              pready22;
    logic              pslverr22;

    modport master (
        output psel22, penable22, pwrite22, paddr22, pwdata22,
        input  prdata22, pready22, pslverr22
    );

    modport slave (
        input  psel22, penable22, pwrite22, paddr22, pwdata22,
        output prdata22, pready22, pslverr22
    );
endinterface

// File: rtl/ttc_apb_if_lite22.sv
// ----------------------------------------------------------------------------
// ttc_apb_if_lite22
// APB3 slave front end for a three-timer TTC. Decodes the byte address into
// one-cycle per-timer write strobes and read-to-clear pulses, and returns
// registered read data from a readback mux over all timer registers.
// Ports:
//   pclk22, n_p_reset22     : clock, synchronous active-low reset
//   apb (slave modport)     : APB3 bus; pwdata22 goes straight to the timers
//   *_reg_sel22 [3]         : per-timer write strobes, bit n = timer n
//   clear_interrupt22 [3]   : per-timer read-to-clear pulse
//   *_regs22                : packed readback from the three timers
// Register map: offset = base + 4*n (timer n = 0..2), bases 0x00 clk_ctrl,
// 0x0C cntr_ctrl, 0x18 counter_val (RO), 0x24 interval, 0x30/0x3C/0x48
// match_1..3, 0x54 interrupt (RO, read-to-clear), 0x60 intr_en.
// ----------------------------------------------------------------------------
module ttc_apb_if_lite22 #(
    parameter int ADDR_W     = 8,
    parameter bit PSLVERR_EN = 1'b1
) (
    input  logic          pclk22,
    input  logic          n_p_reset22,
    ttc_apb_if_lite22_if.slave apb,
    output logic [2:0]    clk_ctrl_reg_sel22,
    output logic [2:0]    cntr_ctrl_reg_sel22,
    output logic [2:0]    interval_reg_sel22,
    output logic [2:0]    match_1_reg_sel22,
    output logic [2:0]    match_2_reg_sel22,
    output logic [2:0]    match_3_reg_sel22,
    output logic [2:0]    intr_en_reg_sel22,
    output logic [2:0]    clear_interrupt22,
    input  logic [20:0]   clk_ctrl_regs22,
    input  logic [20:0]   cntr_ctrl_regs22,
    input  logic [47:0]   counter_val_regs22,
    input  logic [47:0]   interval_regs22,
    input  logic [47:0]   match_1_regs22,
    input  logic [47:0]   match_2_regs22,
    input  logic [47:0]   match_3_regs22,
    input  logic [17:0]   interrupt_regs22,
    input  logic [17:0]   interrupt_en_regs22
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Zero-extended per-timer slice of the 7-bit readback vectors.
    function automatic logic [15:0] pick7(input logic [20:0] v, input logic [1:0] t);
        case (t)
            2'd0:    pick7 = {9'd0, v[6:0]};
            2'd1:    pick7 = {9'd0, v[13:7]};
            2'd2:    pick7 = {9'd0, v[20:14]};
            default: pick7 = 16'd0;
        endcase
    endfunction

    // Per-timer slice of the 16-bit readback vectors.
    function automatic logic [15:0] pick16(input logic [47:0] v, input logic [1:0] t);
        case (t)
            2'd0:    pick16 = v[15:0];
            2'd1:    pick16 = v[31:16];
            2'd2:    pick16 = v[47:32];
            default: pick16 = 16'd0;
        endcase
    endfunction

    // Zero-extended per-timer slice of the 6-bit readback vectors.
    function automatic logic [15:0] pick6(input logic [17:0] v, input logic [1:0] t);
        case (t)
            2'd0:    pick6 = {10'd0, v[5:0]};
            2'd1:    pick6 = {10'd0, v[11:6]};
            2'd2:    pick6 = {10'd0, v[17:12]};
            default: pick6 = 16'd0;
        endcase
    endfunction

    state_t            state_r;
    state_t            phase_s;
    logic [ADDR_W-1:0] paddr_s;
    logic [7:0]        addr_s;
    logic [5:0]        word_s;
    logic [5:0]        group_s;
    logic [1:0]        timer_s;
    logic [2:0]        onehot_s;
    logic              ro_s;
    logic              err_s;
    logic              wr_ok_s;
    logic              rd_ok_s;
    logic [15:0]       mux_s;
    logic              pready_s;
    logic [15:0]       prdata_r;
    logic              err_r;
    logic [2:0]        clr_pend_r;

    assign paddr_s  = apb.paddr22;
    assign addr_s   = paddr_s[7:0];
    assign word_s   = addr_s[7:2];
    // Each register kind occupies three consecutive words, one per timer.
    assign group_s  = word_s / 6'd3;
    assign timer_s  = 2'(word_s - 6'(group_s * 6'd3));
    assign onehot_s = 3'b001 << timer_s;
    assign ro_s     = (group_s == 6'd2) || (group_s == 6'd7);
    assign err_s    = (addr_s[1:0] != 2'b00) || (addr_s > 8'h68) || (apb.pwrite22 && ro_s);
    assign wr_ok_s  = apb.pwrite22 && !err_s;
    assign rd_ok_s  = !apb.pwrite22 && !err_s;

    // The register only tracks whether the current cycle is an access cycle;
    // a setup cycle is recognised from the bus itself so that the decode can
    // be captured at its closing edge and the access completes with no wait.
    always_comb begin
        phase_s = ST_IDLE;
        if (state_r == ST_ACCESS) begin
            phase_s = ST_ACCESS;
        end else if (apb.psel22 && !apb.penable22) begin
            phase_s = ST_SETUP;
        end else begin
            phase_s = ST_IDLE;
        end
    end

    // Readback mux over every timer register, selected by the live address.
    always_comb begin
        mux_s = 16'd0;
        case (group_s)
            6'd0:    mux_s = pick7(clk_ctrl_regs22, timer_s);
            6'd1:    mux_s = pick7(cntr_ctrl_regs22, timer_s);
            6'd2:    mux_s = pick16(counter_val_regs22, timer_s);
            6'd3:    mux_s = pick16(interval_regs22, timer_s);
            6'd4:    mux_s = pick16(match_1_regs22, timer_s);
            6'd5:    mux_s = pick16(match_2_regs22, timer_s);
            6'd6:    mux_s = pick16(match_3_regs22, timer_s);
            6'd7:    mux_s = pick6(interrupt_regs22, timer_s);
            6'd8:    mux_s = pick6(interrupt_en_regs22, timer_s);
            default: mux_s = 16'd0;
        endcase
    end

    assign pready_s      = (state_r == ST_ACCESS) && apb.psel22 && apb.penable22;
    assign apb.pready22  = pready_s;
    assign apb.pslverr22 = PSLVERR_EN && err_r && pready_s;
    assign apb.prdata22  = prdata_r;

    // Transfer FSM: captures decode at the end of setup, holds strobes and
    // read data for the access cycle, then issues any read-to-clear pulse.
    always_ff @(posedge pclk22) begin
        if (!n_p_reset22) begin
            state_r             <= ST_IDLE;
            prdata_r            <= 16'd0;
            err_r               <= 1'b0;
            clr_pend_r          <= 3'b000;
            clear_interrupt22   <= 3'b000;
            clk_ctrl_reg_sel22  <= 3'b000;
            cntr_ctrl_reg_sel22 <= 3'b000;
            interval_reg_sel22  <= 3'b000;
            match_1_reg_sel22   <= 3'b000;
            match_2_reg_sel22   <= 3'b000;
            match_3_reg_sel22   <= 3'b000;
            intr_en_reg_sel22   <= 3'b000;
        end else begin
            case (phase_s)
                ST_SETUP: begin
                    state_r             <= ST_ACCESS;
                    err_r               <= err_s;
                    prdata_r            <= rd_ok_s ? mux_s : 16'd0;
                    clr_pend_r          <= (rd_ok_s && group_s == 6'd7) ? onehot_s : 3'b000;
                    clear_interrupt22   <= 3'b000;
                    clk_ctrl_reg_sel22  <= (wr_ok_s && group_s == 6'd0) ? onehot_s : 3'b000;
                    cntr_ctrl_reg_sel22 <= (wr_ok_s && group_s == 6'd1) ? onehot_s : 3'b000;
                    interval_reg_sel22  <= (wr_ok_s && group_s == 6'd3) ? onehot_s : 3'b000;
                    match_1_reg_sel22   <= (wr_ok_s && group_s == 6'd4) ? onehot_s : 3'b000;
                    match_2_reg_sel22   <= (wr_ok_s && group_s == 6'd5) ? onehot_s : 3'b000;
                    match_3_reg_sel22   <= (wr_ok_s && group_s == 6'd6) ? onehot_s : 3'b000;
                    intr_en_reg_sel22   <= (wr_ok_s && group_s == 6'd8) ? onehot_s : 3'b000;
                end
                ST_ACCESS: begin
                    state_r             <= ST_IDLE;
                    err_r               <= 1'b0;
                    prdata_r            <= 16'd0;
                    clr_pend_r          <= 3'b000;
                    // Clear only once the read really completed; the data
                    // was already captured at setup, before the clear.
                    clear_interrupt22   <= pready_s ? clr_pend_r : 3'b000;
                    clk_ctrl_reg_sel22  <= 3'b000;
                    cntr_ctrl_reg_sel22 <= 3'b000;
                    interval_reg_sel22  <= 3'b000;
                    match_1_reg_sel22   <= 3'b000;
                    match_2_reg_sel22   <= 3'b000;
                    match_3_reg_sel22   <= 3'b000;
                    intr_en_reg_sel22   <= 3'b000;
                end
                default: begin
                    state_r             <= ST_IDLE;
                    err_r               <= 1'b0;
                    prdata_r            <= 16'd0;
                    clr_pend_r          <= 3'b000;
                    clear_interrupt22   <= 3'b000;
                    clk_ctrl_reg_sel22  <= 3'b000;
                    cntr_ctrl_reg_sel22 <= 3'b000;
                    interval_reg_sel22  <= 3'b000;
                    match_1_reg_sel22   <= 3'b000;
                    match_2_reg_sel22   <= 3'b000;
                    match_3_reg_sel22   <= 3'b000;
                    intr_en_reg_sel22   <= 3'b000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ttc_apb_if_lite22.sv
// ----------------------------------------------------------------------------
// tb_ttc_apb_if_lite22
// Drives APB transfers into two front ends (error response enabled and
// disabled) sharing the same bus stimulus and timer readback values. Each
// transfer pushes its expected access-cycle result onto a scoreboard queue;
// a negedge monitor pops it in the access cycle and checks idle values in
// every other cycle.
// ----------------------------------------------------------------------------
module tb_ttc_apb_if_lite22;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        logic [20:0] sel;
        logic [2:0]  clr;
    } exp_t;

    logic        pclk22 = 1'b0;
    logic        n_p_reset22 = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [7:0]  paddr = 8'h00;
    logic [15:0] pwdata = 16'h0000;

    logic [20:0] clk_ctrl_regs22    = {7'h11, 7'h5A, 7'h33};
    logic [20:0] cntr_ctrl_regs22   = {7'h7F, 7'h00, 7'h42};
    logic [47:0] counter_val_regs22 = {16'hC0DE, 16'hBEEF, 16'h0001};
    logic [47:0] interval_regs22    = {16'h3333, 16'h2222, 16'h1111};
    logic [47:0] match_1_regs22     = {16'h0C01, 16'h0B01, 16'h0A01};
    logic [47:0] match_2_regs22     = {16'h0C02, 16'h0B02, 16'h0A02};
    logic [47:0] match_3_regs22     = {16'hA5A5, 16'h5A5A, 16'hFFFF};
    logic [17:0] interrupt_regs22   = {6'h05, 6'h21, 6'h3F};
    logic [17:0] interrupt_en_regs22 = {6'h0A, 6'h15, 6'h2B};

    logic [2:0] clk_a, cntr_a, intv_a, m1_a, m2_a, m3_a, ie_a, clr_a;
    logic [2:0] clk_b, cntr_b, intv_b, m1_b, m2_b, m3_b, ie_b, clr_b;
    logic [20:0] strobe_a, strobe_b;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic acc_phase = 1'b0;
    logic mon_en = 1'b0;
    logic [2:0] clr_exp = 3'b000;

    ttc_apb_if_lite22_if #(.ADDR_W(8)) apb_a ();
    ttc_apb_if_lite22_if #(.ADDR_W(8)) apb_b ();

    assign apb_a.psel22    = psel;
    assign apb_a.penable22 = penable;
    assign apb_a.pwrite22  = pwrite;
    assign apb_a.paddr22   = paddr;
    assign apb_a.pwdata22  = pwdata;
    assign apb_b.psel22    = psel;
    assign apb_b.penable22 = penable;
    assign apb_b.pwrite22  = pwrite;
    assign apb_b.paddr22   = paddr;
    assign apb_b.pwdata22  = pwdata;

    ttc_apb_if_lite22 #(.ADDR_W(8), .PSLVERR_EN(1'b1)) dut_en (
        .pclk22(pclk22), .n_p_reset22(n_p_reset22), .apb(apb_a),
        .clk_ctrl_reg_sel22(clk_a), .cntr_ctrl_reg_sel22(cntr_a),
        .interval_reg_sel22(intv_a), .match_1_reg_sel22(m1_a),
        .match_2_reg_sel22(m2_a), .match_3_reg_sel22(m3_a),
        .intr_en_reg_sel22(ie_a), .clear_interrupt22(clr_a),
        .clk_ctrl_regs22(clk_ctrl_regs22), .cntr_ctrl_regs22(cntr_ctrl_regs22),
        .counter_val_regs22(counter_val_regs22), .interval_regs22(interval_regs22),
        .match_1_regs22(match_1_regs22), .match_2_regs22(match_2_regs22),
        .match_3_regs22(match_3_regs22), .interrupt_regs22(interrupt_regs22),
        .interrupt_en_regs22(interrupt_en_regs22)
    );

    ttc_apb_if_lite22 #(.ADDR_W(8), .PSLVERR_EN(1'b0)) dut_dis (
        .pclk22(pclk22), .n_p_reset22(n_p_reset22), .apb(apb_b),
        .clk_ctrl_reg_sel22(clk_b), .cntr_ctrl_reg_sel22(cntr_b),
        .interval_reg_sel22(intv_b), .match_1_reg_sel22(m1_b),
        .match_2_reg_sel22(m2_b), .match_3_reg_sel22(m3_b),
        .intr_en_reg_sel22(ie_b), .clear_interrupt22(clr_b),
        .clk_ctrl_regs22(clk_ctrl_regs22), .cntr_ctrl_regs22(cntr_ctrl_regs22),
        .counter_val_regs22(counter_val_regs22), .interval_regs22(interval_regs22),
        .match_1_regs22(match_1_regs22), .match_2_regs22(match_2_regs22),
        .match_3_regs22(match_3_regs22), .interrupt_regs22(interrupt_regs22),
        .interrupt_en_regs22(interrupt_en_regs22)
    );

    // Strobe vector layout: {intr_en, match_3, match_2, match_1, interval, cntr_ctrl, clk_ctrl}
    assign strobe_a = {ie_a, m3_a, m2_a, m1_a, intv_a, cntr_a, clk_a};
    assign strobe_b = {ie_b, m3_b, m2_b, m1_b, intv_b, cntr_b, clk_b};

    always #5 pclk22 = ~pclk22;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops in the access cycle, checks quiet outputs otherwise.
    always @(negedge pclk22) begin
        if (mon_en) begin
            logic [2:0] clr_next;
            exp_t e;
            clr_next = 3'b000;
            check_val("clr_en", {29'd0, clr_a}, {29'd0, clr_exp});
            check_val("clr_dis", {29'd0, clr_b}, {29'd0, clr_exp});
            if (acc_phase) begin
                if (sb.size() == 0) begin
                    check_val("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_val("rdy_en", {31'd0, apb_a.pready22}, 32'd1);
                    check_val("rdy_dis", {31'd0, apb_b.pready22}, 32'd1);
                    check_val("rdata_en", {16'd0, apb_a.prdata22}, {16'd0, e.rdata});
                    check_val("rdata_dis", {16'd0, apb_b.prdata22}, {16'd0, e.rdata});
                    check_val("err_en", {31'd0, apb_a.pslverr22}, {31'd0, e.err});
                    check_val("err_dis", {31'd0, apb_b.pslverr22}, 32'd0);
                    check_val("sel_en", {11'd0, strobe_a}, {11'd0, e.sel});
                    check_val("sel_dis", {11'd0, strobe_b}, {11'd0, e.sel});
                    clr_next = e.clr;
                end
            end else begin
                check_val("idle_rdy", {30'd0, apb_a.pready22, apb_b.pready22}, 32'd0);
                check_val("idle_err", {30'd0, apb_a.pslverr22, apb_b.pslverr22}, 32'd0);
                check_val("idle_rdata", {apb_a.prdata22, apb_b.prdata22}, 32'd0);
                check_val("idle_sel", {11'd0, strobe_a | strobe_b}, 32'd0);
            end
            clr_exp = clr_next;
        end
    end

    // One APB transfer; called just after a rising edge. b2b skips the idle cycle.
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [15:0] wdata,
                        input logic [15:0] rdata, input logic err, input logic [20:0] sel,
                        input logic [2:0] clr, input logic b2b, input logic rst_acc);
        exp_t e;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge pclk22); #1;
        penable = 1'b1;
        e.rdata = rdata; e.err = err; e.sel = sel; e.clr = clr;
        sb.push_back(e);
        acc_phase = 1'b1;
        if (rst_acc) n_p_reset22 = 1'b0;
        @(posedge pclk22); #1;
        acc_phase = 1'b0;
        n_p_reset22 = 1'b1;
        if (!b2b) begin
            psel = 1'b0; penable = 1'b0;
            @(posedge pclk22); #1;
        end
    endtask

    initial begin
        repeat (2) @(posedge pclk22);
        #1;
        mon_en = 1'b1;
        repeat (2) @(posedge pclk22);
        #1;
        n_p_reset22 = 1'b1;
        @(posedge pclk22); #1;

        // Reset held during a setup cycle: the following penable must be ignored.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h28; pwdata = 16'hDEAD;
        n_p_reset22 = 1'b0;
        @(posedge pclk22); #1;
        n_p_reset22 = 1'b1; penable = 1'b1;
        @(posedge pclk22); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk22); #1;

        //   wr    addr   wdata     rdata     err   sel          clr     b2b   rst
        xfer(1'b1, 8'h28, 16'h1234, 16'h0000, 1'b0, 21'h000080, 3'b000, 1'b0, 1'b0);
        xfer(1'b0, 8'h20, 16'h0000, 16'hC0DE, 1'b0, 21'h000000, 3'b000, 1'b0, 1'b0);
        xfer(1'b0, 8'h04, 16'h0000, 16'h005A, 1'b0, 21'h000000, 3'b000, 1'b0, 1'b0);
        xfer(1'b0, 8'h58, 16'h0000, 16'h0021, 1'b0, 21'h000000, 3'b010, 1'b0, 1'b0);
        xfer(1'b1, 8'h18, 16'hFFFF, 16'h0000, 1'b1, 21'h000000, 3'b000, 1'b0, 1'b0);
        xfer(1'b0, 8'h6C, 16'h0000, 16'h0000, 1'b1, 21'h000000, 3'b000, 1'b0, 1'b0);
        xfer(1'b0, 8'h02, 16'h0000, 16'h0000, 1'b1, 21'h000000, 3'b000, 1'b0, 1'b0);
        xfer(1'b1, 8'h0C, 16'h0055, 16'h0000, 1'b0, 21'h000008, 3'b000, 1'b1, 1'b0);
        xfer(1'b0, 8'h60, 16'h0000, 16'h002B, 1'b0, 21'h000000, 3'b000, 1'b0, 1'b0);
        xfer(1'b0, 8'h50, 16'h0000, 16'hA5A5, 1'b0, 21'h000000, 3'b000, 1'b0, 1'b0);
        xfer(1'b0, 8'h14, 16'h0000, 16'h007F, 1'b0, 21'h000000, 3'b000, 1'b0, 1'b0);
        xfer(1'b1, 8'h68, 16'h00AA, 16'h0000, 1'b0, 21'h100000, 3'b000, 1'b0, 1'b0);
        xfer(1'b0, 8'h54, 16'h0000, 16'h003F, 1'b0, 21'h000000, 3'b001, 1'b1, 1'b0);
        xfer(1'b0, 8'h5C, 16'h0000, 16'h0005, 1'b0, 21'h000000, 3'b100, 1'b0, 1'b0);
        xfer(1'b1, 8'h54, 16'h0001, 16'h0000, 1'b1, 21'h000000, 3'b000, 1'b0, 1'b0);
        xfer(1'b1, 8'h01, 16'h0001, 16'h0000, 1'b1, 21'h000000, 3'b000, 1'b0, 1'b0);
        xfer(1'b0, 8'h70, 16'h0000, 16'h0000, 1'b1, 21'h000000, 3'b000, 1'b0, 1'b0);
        xfer(1'b0, 8'h30, 16'h0000, 16'h0A01, 1'b0, 21'h000000, 3'b000, 1'b0, 1'b0);
        // Reset at the end of an interrupt read: data returned, clear cancelled.
        xfer(1'b0, 8'h58, 16'h0000, 16'h0021, 1'b0, 21'h000000, 3'b000, 1'b0, 1'b1);

        repeat (2) @(posedge pclk22);
        #1;
        mon_en = 1'b0;
        check_val("sb_drain", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
